// File: rtl/lif_pkg.sv
// Shared definitions for the leaky integrate-and-fire neuron layer.
//   BN_UNITY    : batchnorm scale code meaning 1.0x (scale is in quarters)
//   lif_state_e : sweep controller states
//   sat()       : clamps a wide signed value into a signed field of 'bits' width
package lif_pkg;

  localparam logic [3:0] BN_UNITY = 4'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    FLUSH = 2'd2
  } lif_state_e;

  function automatic int sat(input int v, input int bits);
    int hi;
    int lo;
    int res;
    hi = (1 << (bits - 1)) - 1;
    lo = -(1 << (bits - 1));
    if (v > hi)      res = hi;
    else if (v < lo) res = lo;
    else             res = v;
    return res;
  endfunction

endpackage

// File: rtl/lif_step_unit.sv
// One leaky integrate-and-fire update for a single neuron (purely combinational).
// Inputs : inputs/w (spike vector and binary weight row), u (membrane), r (refractory
//          count) and the frame parameters shift, bn_factor, bn_addend, threshold,
//          refractory.
// Outputs: u_new (next membrane), r_new (next refractory count), spike.
module lif_step_unit
  import lif_pkg::*;
#(
  parameter int SYNAPSES       = 32,
  parameter int MEMBRANE_BITS  = 9,
  parameter int THRESHOLD_BITS = 8,
  parameter int ADDEND_BITS    = 5,
  parameter int REFRACT_BITS   = 3
) (
  input  logic [SYNAPSES-1:0]              inputs,
  input  logic [SYNAPSES-1:0]              w,
  input  logic signed [MEMBRANE_BITS-1:0]  u,
  input  logic [REFRACT_BITS-1:0]          r,
  input  logic [2:0]                       shift,
  input  logic [3:0]                       bn_factor,
  input  logic signed [ADDEND_BITS-1:0]    bn_addend,
  input  logic [THRESHOLD_BITS-1:0]        threshold,
  input  logic [REFRACT_BITS-1:0]          refractory,
  output logic signed [MEMBRANE_BITS-1:0]  u_new,
  output logic [REFRACT_BITS-1:0]          r_new,
  output logic                             spike
);

  int psp;
  int decayed;
  int syn;
  int acc;
  int thr;

  // All arithmetic runs in 32-bit signed so nothing wraps before the clamp.
  always_comb begin
    psp     = $countones(inputs & w) - $countones(inputs & ~w);
    decayed = (shift != 3'd0) ? int'(u) - (int'(u) >>> shift) : int'(u);
    syn     = (psp * int'(bn_factor)) >>> 2;
    thr     = int'(threshold);
    if (r != '0) acc = sat(decayed, MEMBRANE_BITS);
    else         acc = sat(decayed + syn + int'(bn_addend), MEMBRANE_BITS);
    spike   = (r == '0) && (acc >= thr);
    // Reset by subtraction keeps the overshoot above threshold.
    u_new   = MEMBRANE_BITS'(spike ? acc - thr : acc);
    if (r != '0)  r_new = r - REFRACT_BITS'(1);
    else if (spike) r_new = refractory;
    else          r_new = '0;
  end

endmodule

// File: rtl/neuron_lif_array.sv
// Time-multiplexed layer of NEURONS leaky integrate-and-fire neurons sharing one
// step unit. A frame is accepted in IDLE, each neuron is updated in turn during
// SWEEP, and FLUSH publishes the frame's spike vector.
// Ports: clk, rst_n (async active-low); cfg_we/cfg_addr/cfg_wdata weight writes;
//        clear_state; in_valid/in_ready frame handshake with inputs and frame
//        parameters; out_valid/out_idx/out_spike/out_membrane per-neuron results;
//        frame_done pulse and spike_vector.
//
// state | meaning
// IDLE  | waiting for a frame; config writes and clear are honoured here
// SWEEP | updating neuron idx, one per cycle
// FLUSH | last result out, frame_done pulse, spike_vector valid
module neuron_lif_array
  import lif_pkg::*;
#(
  parameter int SYNAPSES       = 32,
  parameter int NEURONS        = 8,
  localparam int STAGE         = $clog2(SYNAPSES),
  parameter int MEMBRANE_BITS  = STAGE + 4,
  parameter int THRESHOLD_BITS = MEMBRANE_BITS - 1,
  parameter int ADDEND_BITS    = STAGE,
  parameter int REFRACT_BITS   = 3,
  localparam int IDX_BITS      = $clog2(NEURONS)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             cfg_we,
  input  logic [IDX_BITS-1:0]              cfg_addr,
  input  logic [SYNAPSES-1:0]              cfg_wdata,
  input  logic                             clear_state,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [SYNAPSES-1:0]              inputs,
  input  logic [2:0]                       shift,
  input  logic [3:0]                       bn_factor,
  input  logic signed [ADDEND_BITS-1:0]    bn_addend,
  input  logic [THRESHOLD_BITS-1:0]        threshold,
  input  logic [REFRACT_BITS-1:0]          refractory,
  output logic                             out_valid,
  output logic [IDX_BITS-1:0]              out_idx,
  output logic                             out_spike,
  output logic signed [MEMBRANE_BITS-1:0]  out_membrane,
  output logic                             frame_done,
  output logic [NEURONS-1:0]               spike_vector
);

  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NEURONS - 1);

  lif_state_e state_q, state_d;
  logic [IDX_BITS-1:0] idx_q, idx_d;

  logic [SYNAPSES-1:0]             weight_q [NEURONS];
  logic [SYNAPSES-1:0]             weight_d [NEURONS];
  logic signed [MEMBRANE_BITS-1:0] mem_q    [NEURONS];
  logic signed [MEMBRANE_BITS-1:0] mem_d    [NEURONS];
  logic [REFRACT_BITS-1:0]         refr_q   [NEURONS];
  logic [REFRACT_BITS-1:0]         refr_d   [NEURONS];

  logic [SYNAPSES-1:0]             f_inputs_q, f_inputs_d;
  logic [2:0]                      f_shift_q, f_shift_d;
  logic [3:0]                      f_bn_q, f_bn_d;
  logic signed [ADDEND_BITS-1:0]   f_addend_q, f_addend_d;
  logic [THRESHOLD_BITS-1:0]       f_thr_q, f_thr_d;
  logic [REFRACT_BITS-1:0]         f_refr_q, f_refr_d;

  logic [NEURONS-1:0]              spike_acc_q, spike_acc_d;
  logic [NEURONS-1:0]              spike_vector_q, spike_vector_d;
  logic                            out_valid_q, out_valid_d;
  logic [IDX_BITS-1:0]             out_idx_q, out_idx_d;
  logic                            out_spike_q, out_spike_d;
  logic signed [MEMBRANE_BITS-1:0] out_membrane_q, out_membrane_d;

  logic signed [MEMBRANE_BITS-1:0] step_u;
  logic [REFRACT_BITS-1:0]         step_r;
  logic                            step_spike;

  lif_step_unit #(
    .SYNAPSES       (SYNAPSES),
    .MEMBRANE_BITS  (MEMBRANE_BITS),
    .THRESHOLD_BITS (THRESHOLD_BITS),
    .ADDEND_BITS    (ADDEND_BITS),
    .REFRACT_BITS   (REFRACT_BITS)
  ) u_step (
    .inputs     (f_inputs_q),
    .w          (weight_q[idx_q]),
    .u          (mem_q[idx_q]),
    .r          (refr_q[idx_q]),
    .shift      (f_shift_q),
    .bn_factor  (f_bn_q),
    .bn_addend  (f_addend_q),
    .threshold  (f_thr_q),
    .refractory (f_refr_q),
    .u_new      (step_u),
    .r_new      (step_r),
    .spike      (step_spike)
  );

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    weight_d       = weight_q;
    mem_d          = mem_q;
    refr_d         = refr_q;
    f_inputs_d     = f_inputs_q;
    f_shift_d      = f_shift_q;
    f_bn_d         = f_bn_q;
    f_addend_d     = f_addend_q;
    f_thr_d        = f_thr_q;
    f_refr_d       = f_refr_q;
    spike_acc_d    = spike_acc_q;
    spike_vector_d = spike_vector_q;
    out_valid_d    = 1'b0;
    out_idx_d      = '0;
    out_spike_d    = 1'b0;
    out_membrane_d = '0;

    case (state_q)
      IDLE: begin
        // Clear is applied before a same-cycle frame so the frame sees zero state.
        if (clear_state) begin
          for (int i = 0; i < NEURONS; i++) begin
            mem_d[i]  = '0;
            refr_d[i] = '0;
          end
        end
        if (cfg_we && (int'(cfg_addr) < NEURONS)) weight_d[cfg_addr] = cfg_wdata;
        if (in_valid) begin
          f_inputs_d  = inputs;
          f_shift_d   = shift;
          f_bn_d      = bn_factor;
          f_addend_d  = bn_addend;
          f_thr_d     = threshold;
          f_refr_d    = refractory;
          spike_acc_d = '0;
          idx_d       = '0;
          state_d     = SWEEP;
        end
      end
      SWEEP: begin
        mem_d[idx_q]       = step_u;
        refr_d[idx_q]      = step_r;
        spike_acc_d[idx_q] = step_spike;
        out_valid_d        = 1'b1;
        out_idx_d          = idx_q;
        out_spike_d        = step_spike;
        out_membrane_d     = step_u;
        if (idx_q == LAST_IDX) begin
          spike_vector_d = spike_acc_d;
          idx_d          = '0;
          state_d        = FLUSH;
        end else begin
          idx_d = idx_q + IDX_BITS'(1);
        end
      end
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      for (int i = 0; i < NEURONS; i++) begin
        weight_q[i] <= '0;
        mem_q[i]    <= '0;
        refr_q[i]   <= '0;
      end
      f_inputs_q     <= '0;
      f_shift_q      <= '0;
      f_bn_q         <= BN_UNITY;
      f_addend_q     <= '0;
      f_thr_q        <= '0;
      f_refr_q       <= '0;
      spike_acc_q    <= '0;
      spike_vector_q <= '0;
      out_valid_q    <= 1'b0;
      out_idx_q      <= '0;
      out_spike_q    <= 1'b0;
      out_membrane_q <= '0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      weight_q       <= weight_d;
      mem_q          <= mem_d;
      refr_q         <= refr_d;
      f_inputs_q     <= f_inputs_d;
      f_shift_q      <= f_shift_d;
      f_bn_q         <= f_bn_d;
      f_addend_q     <= f_addend_d;
      f_thr_q        <= f_thr_d;
      f_refr_q       <= f_refr_d;
      spike_acc_q    <= spike_acc_d;
      spike_vector_q <= spike_vector_d;
      out_valid_q    <= out_valid_d;
      out_idx_q      <= out_idx_d;
      out_spike_q    <= out_spike_d;
      out_membrane_q <= out_membrane_d;
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign frame_done   = (state_q == FLUSH);
  assign spike_vector = spike_vector_q;
  assign out_valid    = out_valid_q;
  assign out_idx      = out_idx_q;
  assign out_spike    = out_spike_q;
  assign out_membrane = out_membrane_q;

endmodule

// File: tb/tb_neuron_lif_array.sv
// Bench for neuron_lif_array with 8 synapses and 4 neurons (membrane range -64..63).
// A frame-level model predicts every result; literal checks pin the model.
module tb_neuron_lif_array;

  localparam int S    = 8;
  localparam int N    = 4;
  localparam int LAST = N + 1;  // cycles after acceptance until the frame_done cycle

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              cfg_we = 1'b0;
  logic [1:0]        cfg_addr = '0;
  logic [S-1:0]      cfg_wdata = '0;
  logic              clear_state = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [S-1:0]      inputs = '0;
  logic [2:0]        shift = '0;
  logic [3:0]        bn_factor = 4'd4;
  logic signed [2:0] bn_addend = '0;
  logic [5:0]        threshold = '0;
  logic [2:0]        refractory = '0;
  logic              out_valid;
  logic [1:0]        out_idx;
  logic              out_spike;
  logic signed [6:0] out_membrane;
  logic              frame_done;
  logic [N-1:0]      spike_vector;

  neuron_lif_array #(.SYNAPSES(S), .NEURONS(N)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .clear_state(clear_state), .in_valid(in_valid), .in_ready(in_ready), .inputs(inputs),
    .shift(shift), .bn_factor(bn_factor), .bn_addend(bn_addend), .threshold(threshold),
    .refractory(refractory), .out_valid(out_valid), .out_idx(out_idx), .out_spike(out_spike),
    .out_membrane(out_membrane), .frame_done(frame_done), .spike_vector(spike_vector)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level model ----------------
  int           m_mem [N];
  int           m_ref [N];
  logic [S-1:0] m_w   [N];
  int           r_mem [N];
  int           r_spk [N];
  int           phase = 0;
  logic [N-1:0] pend_sv = '0;
  logic [N-1:0] exp_sv = '0;

  function automatic int fdiv(input int v, input int s);
    int p;
    int q;
    p = 1 << s;
    q = v / p;
    if (v < 0 && q * p != v) q = q - 1;
    return q;
  endfunction

  function automatic int clampm(input int v);
    if (v > 63) return 63;
    if (v < -64) return -64;
    return v;
  endfunction

  task automatic model_frame();
    for (int n = 0; n < N; n++) begin
      int psp;
      int dec;
      int acc;
      int spk;
      psp = 0;
      for (int i = 0; i < S; i++)
        if (inputs[i]) psp += m_w[n][i] ? 1 : -1;
      dec = (shift == 0) ? m_mem[n] : m_mem[n] - fdiv(m_mem[n], int'(shift));
      spk = 0;
      if (m_ref[n] > 0) begin
        acc = dec;
        m_ref[n] = m_ref[n] - 1;
      end else begin
        acc = clampm(dec + fdiv(psp * int'(bn_factor), 2) + int'(bn_addend));
        if (acc >= int'(threshold)) begin
          spk = 1;
          acc = acc - int'(threshold);
          m_ref[n] = int'(refractory);
        end
      end
      m_mem[n]   = acc;
      r_mem[n]   = acc;
      r_spk[n]   = spk;
      pend_sv[n] = (spk != 0);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < N; n++) begin
        m_mem[n] = 0;
        m_ref[n] = 0;
        m_w[n]   = '0;
      end
      phase  = 0;
      exp_sv = '0;
    end else if (phase == 0) begin
      if (clear_state)
        for (int n = 0; n < N; n++) begin
          m_mem[n] = 0;
          m_ref[n] = 0;
        end
      if (cfg_we) m_w[cfg_addr] = cfg_wdata;
      if (in_valid) begin
        model_frame();
        phase = 1;
      end
    end else begin
      phase = (phase == LAST) ? 0 : phase + 1;
      if (phase == LAST) exp_sv = pend_sv;
    end
  end

  // ---------------- compare process ----------------
  int           dut_mem [N];
  int           dut_spk [N];
  logic [N-1:0] dut_sv = '0;
  int           done_cnt = 0;

  always @(negedge clk) begin
    check("ctl_ready_valid_done", int'({in_ready, out_valid, frame_done}),
          int'({phase == 0, phase >= 2, phase == LAST}));
    check("spike_vector", int'(spike_vector), int'(exp_sv));
    if (phase >= 2) begin
      check("out_idx", int'(out_idx), phase - 2);
      check("out_spike", int'(out_spike), r_spk[phase - 2]);
      check("out_membrane", int'(out_membrane), r_mem[phase - 2]);
    end
    if (out_valid) begin
      dut_mem[out_idx] = int'(out_membrane);
      dut_spk[out_idx] = int'(out_spike);
    end
    if (frame_done) begin
      dut_sv = spike_vector;
      done_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic wr(input int n, input logic [S-1:0] w);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = 2'(n); cfg_wdata = w;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic clr();
    @(negedge clk);
    clear_state = 1'b1;
    @(negedge clk);
    clear_state = 1'b0;
  endtask

  task automatic set_par(input logic [S-1:0] inp, input int sh, input int bn,
                         input int add, input int thr, input int rf);
    inputs = inp; shift = 3'(sh); bn_factor = 4'(bn);
    bn_addend = 3'(add); threshold = 6'(thr); refractory = 3'(rf);
  endtask

  task automatic frame(input logic [S-1:0] inp, input int sh, input int bn, input int add,
                       input int thr, input int rf, input bit clr_too = 1'b0);
    int start;
    int n;
    @(negedge clk);
    set_par(inp, sh, bn, add, thr, rf);
    clear_state = clr_too;
    in_valid = 1'b1;
    start = done_cnt;
    @(negedge clk);
    in_valid = 1'b0;
    clear_state = 1'b0;
    n = 0;
    while (done_cnt == start && n < 3 * N) begin
      @(negedge clk);
      n++;
    end
    check("frame_done_count", done_cnt - start, 1);
  endtask

  task automatic lit(input string tag, input int n, input int mem, input int spk);
    check({tag, "_mem"}, dut_mem[n], mem);
    check({tag, "_spk"}, dut_spk[n], spk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    int n;
    int dexp [5] = '{8, 4, 2, 1, 1};
    int s0 [4] = '{30, 60, 0, 30};
    int s1 [4] = '{-30, -60, -64, -64};
    int rm [5] = '{8, 6, 6, 6, 4};
    int rs [5] = '{0, 1, 0, 0, 1};

    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_spike_vector", int'(spike_vector), 0);
    #2 rst_n = 1'b1;

    // Integration to threshold: neuron0 all +1, others all -1.
    wr(0, 8'hFF);
    frame(8'hFF, 0, 4, 0, 20, 0);
    lit("int_f1_n0", 0, 8, 0);
    lit("int_f1_n1", 1, -8, 0);
    check("int_f1_sv", int'(dut_sv), 0);
    frame(8'hFF, 0, 4, 0, 20, 0);
    lit("int_f2_n0", 0, 16, 0);
    frame(8'hFF, 0, 4, 0, 20, 0);
    lit("int_f3_n0", 0, 4, 1);
    check("int_f3_sv", int'(dut_sv), 1);

    // Decay with shift 1 from 16.
    clr();
    frame(8'hFF, 0, 4, 0, 63, 0);
    frame(8'hFF, 0, 4, 0, 63, 0);
    lit("dec_start_n0", 0, 16, 0);
    for (int i = 0; i < 5; i++) begin
      frame(8'h00, 1, 4, 0, 63, 0);
      lit("dec_n0", 0, dexp[i], 0);
    end
    // Clear together with a frame: neuron0 starts from 0, neuron1 lands at -3.
    frame(8'h07, 0, 4, 0, 63, 0, 1'b1);
    lit("clr_frame_n0", 0, 3, 0);
    lit("clr_frame_n1", 1, -3, 0);
    frame(8'h00, 1, 4, 0, 63, 0);
    lit("dec_neg1_n1", 1, -1, 0);
    frame(8'h00, 1, 4, 0, 63, 0);
    lit("dec_neg2_n1", 1, 0, 0);

    // Saturation in both directions, bn 15.
    clr();
    for (int i = 0; i < 4; i++) begin
      frame(8'hFF, 0, 15, 0, 63, 0);
      lit("sat_n0", 0, s0[i], (i == 2) ? 1 : 0);
      lit("sat_n1", 1, s1[i], 0);
    end

    // Refractory 2.
    clr();
    for (int i = 0; i < 5; i++) begin
      frame(8'hFF, 0, 4, 0, 10, 2);
      lit("refr_n0", 0, rm[i], rs[i]);
    end

    // Mixed patterns, checked against the model only.
    wr(2, 8'hA5);
    wr(3, 8'h3C);
    frame(8'h5A, 2, 6, -3, 5, 1);
    frame(8'hC3, 1, 1, 3, 0, 0);
    frame(8'hFF, 3, 9, -4, 12, 3);
    frame(8'h00, 0, 4, 0, 0, 0);
    frame(8'h81, 0, 4, 2, 1, 1);

    // Back-to-back frames with in_valid held; mid-frame config and clear are ignored.
    @(negedge clk);
    set_par(8'hFF, 1, 4, 1, 30, 1);
    in_valid = 1'b1;
    start = done_cnt;
    for (int i = 0; i < 20; i++) begin
      if (i == 3) begin
        clear_state = 1'b1; cfg_we = 1'b1; cfg_addr = 2'd1; cfg_wdata = 8'h0F;
      end else begin
        clear_state = 1'b0; cfg_we = 1'b0;
      end
      @(negedge clk);
    end
    in_valid = 1'b0; clear_state = 1'b0; cfg_we = 1'b0;
    repeat (N + 3) @(negedge clk);
    check("hs_frame_count", done_cnt - start, 4);

    // Reset in the middle of a sweep.
    @(negedge clk);
    set_par(8'hFF, 0, 4, 0, 63, 0);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!(out_valid && out_idx == 2'd1) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_reached_idx1", int'(out_valid && out_idx == 2'd1), 1);
    start = done_cnt;
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_in_ready", int'(in_ready), 1);
    check("rst_mid_out_valid", int'(out_valid), 0);
    check("rst_mid_spike_vector", int'(spike_vector), 0);
    #2 rst_n = 1'b1;
    repeat (N + 2) @(negedge clk);
    check("rst_mid_no_frame_done", done_cnt - start, 0);
    frame(8'hFF, 0, 4, 0, 63, 0);
    for (int i = 0; i < N; i++) lit("post_rst", i, -8, 0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/neuron_lif_array.md
Name: neuron_lif_array

Overview:
- Time-multiplexed layer of NEURONS leaky integrate-and-fire neurons.
- All neurons share one SYNAPSES-wide input spike vector per timestep and one arithmetic step unit.
- Per-neuron binary weights, membranes and refractory counters are held in internal registers.
- Sits between an input spike source and the next layer; emits one spike/membrane result per neuron plus a per-frame spike vector.

Parameters:
- SYNAPSES, 32, input synapses per neuron (power of two, >=4)
- NEURONS, 8, neurons in the layer (>=2)
- STAGE, $clog2(SYNAPSES), derived localparam
- MEMBRANE_BITS, STAGE+4, signed membrane width
- THRESHOLD_BITS, MEMBRANE_BITS-1, unsigned threshold width
- ADDEND_BITS, STAGE, signed batchnorm addend width
- REFRACT_BITS, 3, refractory counter width
- IDX_BITS, $clog2(NEURONS), derived localparam

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_we  in  1  weight write strobe; accepted only when in_ready=1
- cfg_addr  in  IDX_BITS  neuron index for weight write
- cfg_wdata  in  SYNAPSES  weight row; bit 1 = +1, bit 0 = -1
- clear_state  in  1  synchronous clear of all membranes and refractory counters; honoured only when idle
- in_valid  in  1  frame valid
- in_ready  out  1  high when idle
- inputs  in  SYNAPSES  input spike vector, captured on handshake
- shift  in  3  decay shift
- bn_factor  in  4  unsigned scale; 4 = 1.0x
- bn_addend  in  ADDEND_BITS  signed bias
- threshold  in  THRESHOLD_BITS  firing threshold
- refractory  in  REFRACT_BITS  refractory steps after a spike
- out_valid  out  1  per-neuron result strobe
- out_idx  out  IDX_BITS  neuron index of the result
- out_spike  out  1  spike of that neuron
- out_membrane  out  MEMBRANE_BITS  new membrane of that neuron
- frame_done  out  1  one-cycle pulse after the last neuron
- spike_vector  out  NEURONS  spikes of the completed frame; held until the next frame_done

Behaviour:
- Reset (rst_n low, async): IDLE state; all membranes, refractory counters and weights = 0; every output = 0 except in_ready = 1.
- FSM IDLE:
  - in_ready = 1.
  - in_valid & in_ready captures inputs, shift, bn_factor, bn_addend, threshold and refractory into frame registers, then goes to SWEEP with idx = 0.
  - clear_state and cfg_we are acted on only in IDLE. If in_valid and clear_state arrive in the same cycle, the clear applies first and the frame then sees zero state.
- FSM SWEEP:
  - in_ready = 0.
  - Processes neuron idx each cycle; idx increments. After idx = NEURONS-1, goes to FLUSH.
- FSM FLUSH: one cycle; frame_done = 1 and spike_vector updated; back to IDLE.
- Results are registered one cycle after each neuron is processed: out_valid high for exactly NEURONS consecutive cycles, idx in order.
- The last out_valid coincides with frame_done.
- Handshake to next frame: in_ready returns the cycle after frame_done, so the minimum frame period is NEURONS+2 cycles.
- cfg_we, in_valid and clear_state are ignored outside IDLE; in_valid held high is accepted exactly once per idle period.
- Step arithmetic, per neuron, all signed, evaluated at full width before clamping:
  - psp = popcount(inputs & w) - popcount(inputs & ~w), range -SYNAPSES..+SYNAPSES.
  - decayed = u - (u >>> shift) when shift != 0, else u. Arithmetic shift: negative values decay toward 0 and stick at -1 only when shift = 0.
  - If the refractory counter r > 0: acc = decayed and r decrements.
  - Else acc = decayed + ((psp * bn_factor) >>> 2) + bn_addend.
  - acc saturates to [-2^(MEMBRANE_BITS-1), 2^(MEMBRANE_BITS-1)-1]; no wrap-around is allowed.
- Spike and reset-by-subtraction:
  - spike = (r == 0) & (acc >= threshold, threshold zero-extended).
  - On spike: u_new = acc - threshold and r = refractory.
  - Otherwise u_new = acc.
- threshold = 0 makes every non-refractory neuron with acc >= 0 spike.
- rst_n asserted mid-sweep aborts the frame with no frame_done; state is fully reset.

Decomposition:
- Package lif_pkg holds:
  - the saturation helper function;
  - the BN unity constant (4'd4);
  - the state enum IDLE/SWEEP/FLUSH.
- Sub-module lif_step_unit, combinational: inputs, w, u, r and frame parameters in; u_new, r_new and spike out. It is reused from the single-neuron path.

Test Plan (SYNAPSES=8, NEURONS=4, MEMBRANE_BITS=7, range -64..63):
- Reset, then release -> in_ready=1, out_valid=0, spike_vector=0, all membranes read 0 on the first frame.
- Neuron0 weights 0xFF; inputs 0xFF, shift 0, bn 4, addend 0, thr 20, refr 0; three frames -> neuron0 membrane 8, 16, then spike with membrane 4; spike_vector[0]=1 only on frame 3.
- Decay: neuron membrane 16, inputs 0, shift 1 -> membranes 8, 4, 2, 1, 1; from -3 -> -1, 0.
- Saturation: weights 0x00, inputs 0xFF, bn 15 -> -30, -60, -64, -64; mirrored with weights 0xFF and thr 63 -> 30, 60, 63 (spike, membrane 0).
- Refractory 2: neuron spikes at frame k -> frames k+1 and k+2 ignore psp (decay only, no spike), and integration resumes at k+3.
- Handshake: in_valid held high for 20 cycles -> frames start every 6 cycles, out_idx 0..3 in order, frame_done coincides with out_idx 3. rst_n pulsed at out_idx 1 -> no frame_done, all state 0.
